clock_core: RTL and testbench

- Timekeeping datapath that responds to the clock/alarm mode controller's control outputs (clockon, hset, mset, alarmon, ahset, amset, sel1, sel2, h1224).
- Holds the running time (hh:mm:ss) and the alarm time (hh:mm), and applies the set-button increments the controller enables.
- Raises the alarm ring and drives four BCD display digits plus a PM indicator to the seven-segment driver.

---
 rtl/clock_core_pkg.sv | 15 +
 rtl/clock_core_bin2bcd.sv | 19 +
 rtl/clock_core.sv | 185 ++++++++++++++++++
 tb/tb_clock_core.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_core_pkg.sv
// Shared constants and display-view encodings for the clock/alarm timekeeping core.
package clock_core_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    VIEW_ALARM = 2'b00,
    VIEW_MMSS  = 2'b01,
    VIEW_TIME  = 2'b10,
    VIEW_STAT  = 2'b11
  } view_t;

endpackage

// File: rtl/clock_core_bin2bcd.sv
// Combinational 6-bit binary to two-digit BCD converter for one displayed field.
module clock_core_bin2bcd (
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    if      (bin >= 6'd60) tens = 4'd6;
    else if (bin >= 6'd50) tens = 4'd5;
    else if (bin >= 6'd40) tens = 4'd4;
    else if (bin >= 6'd30) tens = 4'd3;
    else if (bin >= 6'd20) tens = 4'd2;
    else if (bin >= 6'd10) tens = 4'd1;
    else                   tens = 4'd0;
    units = 4'(bin - 6'(tens) * 6'd10);
  end

endmodule

// File: rtl/clock_core.sv
// Timekeeping datapath: one-second prescaler, time/alarm counters with set buttons,
// alarm ring timer and a registered four-digit BCD display with PM flag.
module clock_core
  import clock_core_pkg::*;
#(
  parameter int DIV          = 50000000,
  parameter int RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clockon,
  input  logic       hset,
  input  logic       mset,
  input  logic       alarmon,
  input  logic       ahset,
  input  logic       amset,
  input  logic       h1224,
  input  logic       sel1,
  input  logic       sel2,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       pm,
  output logic       alarm_ring,
  output logic       tick
);

  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RING_W = $clog2(RING_SECONDS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECONDS);

  function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic [5:0] lim);
    return (v == lim) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] step_hour(input logic [4:0] v);
    return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] fmt_hour(input logic [4:0] h, input logic h12);
    if (!h12)        return h;
    if (h == 5'd0)   return 5'd12;
    if (h > 5'd12)   return h - 5'd12;
    return h;
  endfunction

  logic [CNT_W-1:0]  pre_cnt;
  logic [5:0]        sec, minute, al_min;
  logic [4:0]        hour, al_hour;
  logic [5:0]        sec_n, minute_n, al_min_n;
  logic [4:0]        hour_n, al_hour_n;
  logic [RING_W-1:0] ring_cnt;
  logic              set_any, dismiss, advance, trigger;

  assign tick    = (pre_cnt == CNT_LAST);
  assign set_any = inc & (hset | mset | ahset | amset);
  assign dismiss = inc & ~(hset | mset | ahset | amset);
  // A set in the same cycle as a tick wins; the tick is lost for the time counter.
  assign advance = tick & clockon & ~set_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 pre_cnt <= '0;
    else if (pre_cnt == CNT_LAST) pre_cnt <= '0;
    else                        pre_cnt <= pre_cnt + CNT_W'(1);
  end

  always_comb begin
    sec_n     = sec;
    minute_n  = minute;
    hour_n    = hour;
    al_hour_n = al_hour;
    al_min_n  = al_min;
    if (inc && hset) begin
      hour_n = step_hour(hour);
    end else if (inc && mset) begin
      minute_n = step_sixty(minute, MIN_MAX);
      sec_n    = 6'd0;
    end else if (inc && ahset) begin
      al_hour_n = step_hour(al_hour);
    end else if (inc && amset) begin
      al_min_n = step_sixty(al_min, MIN_MAX);
    end else if (advance) begin
      sec_n = step_sixty(sec, SEC_MAX);
      if (sec == SEC_MAX) begin
        minute_n = step_sixty(minute, MIN_MAX);
        if (minute == MIN_MAX) hour_n = step_hour(hour);
      end
    end
    trigger = advance && alarmon && (sec == SEC_MAX) &&
              (minute_n == al_min) && (hour_n == al_hour);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec     <= '0;
      minute  <= '0;
      hour    <= '0;
      al_hour <= '0;
      al_min  <= '0;
    end else begin
      sec     <= sec_n;
      minute  <= minute_n;
      hour    <= hour_n;
      al_hour <= al_hour_n;
      al_min  <= al_min_n;
    end
  end

  // Ring timer: counts down one per tick, any dismiss source clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (!alarmon) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (trigger) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= RING_LOAD;
    end else if (dismiss) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (alarm_ring && tick) begin
      if (ring_cnt <= RING_W'(1)) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else begin
        ring_cnt <= ring_cnt - RING_W'(1);
      end
    end
  end

  view_t      view;
  logic [4:0] hour_src, hour_fmt;
  logic [5:0] left_bin, right_bin;
  logic [3:0] left_t, left_u, right_t, right_u;
  logic       pm_n;

  always_comb begin
    view      = view_t'({sel1, sel2});
    hour_src  = (view == VIEW_ALARM) ? al_hour : hour;
    hour_fmt  = fmt_hour(hour_src, h1224);
    left_bin  = {1'b0, hour_fmt};
    right_bin = (view == VIEW_ALARM) ? al_min : minute;
    pm_n      = h1224 && (hour_src >= 5'd12);
    if (view == VIEW_MMSS) begin
      left_bin  = minute;
      right_bin = sec;
      pm_n      = 1'b0;
    end
  end

  clock_core_bin2bcd u_left (
    .bin   (left_bin),
    .tens  (left_t),
    .units (left_u)
  );

  clock_core_bin2bcd u_right (
    .bin   (right_bin),
    .tens  (right_t),
    .units (right_u)
  );

  // Display register stage: one clk behind the counters and selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp3 <= '0;
      disp2 <= '0;
      disp1 <= '0;
      disp0 <= '0;
      pm    <= 1'b0;
    end else begin
      disp3 <= left_t;
      disp2 <= left_u;
      disp1 <= right_t;
      disp0 <= right_u;
      pm    <= pm_n;
    end
  end

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core with a fast prescaler and a short ring time.
module tb_clock_core;

  localparam int DIV = 4;
  localparam int RS  = 5;

  logic       clk = 1'b0;
  logic       reset, inc, clockon, hset, mset, alarmon, ahset, amset, h1224, sel1, sel2;
  logic [3:0] disp3, disp2, disp1, disp0;
  logic       pm, alarm_ring, tick;
  wire [15:0] digits = {disp3, disp2, disp1, disp0};

  int checks   = 0;
  int failures = 0;

  clock_core #(.DIV(DIV), .RING_SECONDS(RS)) dut (
    .clk        (clk),
    .reset      (reset),
    .inc        (inc),
    .clockon    (clockon),
    .hset       (hset),
    .mset       (mset),
    .alarmon    (alarmon),
    .ahset      (ahset),
    .amset      (amset),
    .h1224      (h1224),
    .sel1       (sel1),
    .sel2       (sel2),
    .disp3      (disp3),
    .disp2      (disp2),
    .disp1      (disp1),
    .disp0      (disp0),
    .pm         (pm),
    .alarm_ring (alarm_ring),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      inc = 1'b1;
      cyc(1);
      inc = 1'b0;
      cyc(1);
    end
  endtask

  // Returns just after the clock edge that consumes the n-th observed tick.
  task automatic run_ticks(input int n, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int c = 0; c < n * DIV + 2 * DIV; c++) begin
      if (tick === 1'b1) seen++;
      if (seen == n) begin
        cyc(1);
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cyc(2);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++;
    if ({pm, alarm_ring, tick} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {pm, alarm_ring, tick});
    end
    reset = 1'b1;
  endtask

  task automatic test_tick;
    int ticks = 0;
    int first = -1;
    sel1 = 1'b1; sel2 = 1'b0; clockon = 1'b1;
    for (int i = 0; i < 240; i++) begin
      cyc(1);
      if (tick === 1'b1) begin
        if (first < 0) first = i;
        ticks++;
      end
    end
    checks++;
    if (ticks !== 60) begin failures++; $display("FAIL tick_count got=%0d exp=60", ticks); end
    checks++;
    if (first !== 2) begin failures++; $display("FAIL tick_first got=%0d exp=2", first); end
    clockon = 1'b0;
    cyc(1);
    checks++;
    if (digits !== 16'h0001) begin failures++; $display("FAIL tick_hhmm got=%h exp=0001", digits); end
    sel1 = 1'b0; sel2 = 1'b1;
    cyc(1);
    checks++;
    if (digits !== 16'h0100) begin failures++; $display("FAIL tick_mmss got=%h exp=0100", digits); end
    cyc(8);
    checks++;
    if ({digits, pm} !== {16'h0100, 1'b0}) begin
      failures++; $display("FAIL frozen got=%h/%b exp=0100/0", digits, pm);
    end
  endtask

  task automatic test_rollover;
    bit ok;
    sel1 = 1'b1; sel2 = 1'b0;
    hset = 1'b1; pulses(23); hset = 1'b0;
    mset = 1'b1; pulses(58); mset = 1'b0;
    checks++;
    if (digits !== 16'h2359) begin failures++; $display("FAIL preload got=%h exp=2359", digits); end
    clockon = 1'b1;
    run_ticks(59, ok);
    run_ticks(1, ok);
    clockon = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL rollover_wait got=timeout exp=tick"); end
    cyc(1);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("FAIL rollover_hhmm got=%h exp=0000", digits); end
    sel1 = 1'b0; sel2 = 1'b1;
    cyc(1);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("FAIL rollover_mmss got=%h exp=0000", digits); end
    sel1 = 1'b1; sel2 = 1'b0; h1224 = 1'b1;
    cyc(1);
    checks++;
    if ({digits, pm} !== {16'h1200, 1'b0}) begin
      failures++; $display("FAIL midnight_12h got=%h/%b exp=1200/0", digits, pm);
    end
  endtask

  task automatic test_hour12;
    hset = 1'b1; pulses(14); hset = 1'b0;
    checks++;
    if ({digits, pm} !== {16'h0200, 1'b1}) begin
      failures++; $display("FAIL hour14_12h got=%h/%b exp=0200/1", digits, pm);
    end
    h1224 = 1'b0;
    cyc(1);
    checks++;
    if ({digits, pm} !== {16'h1400, 1'b0}) begin
      failures++; $display("FAIL hour14_24h got=%h/%b exp=1400/0", digits, pm);
    end
  endtask

  task automatic test_priority;
    hset = 1'b1; mset = 1'b1; pulses(1); hset = 1'b0; mset = 1'b0;
    checks++;
    if (digits !== 16'h1500) begin failures++; $display("FAIL prio_hset got=%h exp=1500", digits); end
    sel1 = 1'b0; sel2 = 1'b0;
    amset = 1'b1; pulses(59);
    checks++;
    if (digits !== 16'h0059) begin failures++; $display("FAIL amin59 got=%h exp=0059", digits); end
    pulses(1);
    checks++;
    if (digits !== 16'h0000) begin failures++; $display("FAIL amin_wrap got=%h exp=0000", digits); end
    ahset = 1'b1; pulses(1); amset = 1'b0;
    checks++;
    if (digits !== 16'h0100) begin failures++; $display("FAIL prio_ahset got=%h exp=0100", digits); end
    pulses(23); ahset = 1'b0;
    amset = 1'b1; pulses(2); amset = 1'b0;
    checks++;
    if (digits !== 16'h0002) begin failures++; $display("FAIL alarm_0002 got=%h exp=0002", digits); end
    h1224 = 1'b1;
    cyc(1);
    checks++;
    if ({digits, pm} !== {16'h1202, 1'b0}) begin
      failures++; $display("FAIL alarm_12h got=%h/%b exp=1202/0", digits, pm);
    end
    h1224 = 1'b0;
    sel1 = 1'b1;
    cyc(1);
    checks++;
    if (digits !== 16'h1500) begin failures++; $display("FAIL time_kept got=%h exp=1500", digits); end
  endtask

  task automatic test_alarm;
    bit ok;
    int rt = 0;
    hset = 1'b1; pulses(9); hset = 1'b0;
    mset = 1'b1; pulses(1); mset = 1'b0;
    alarmon = 1'b1; clockon = 1'b1;
    run_ticks(59, ok);
    checks++;
    if (alarm_ring !== 1'b0) begin failures++; $display("FAIL ring_early got=%b exp=0", alarm_ring); end
    run_ticks(1, ok);
    clockon = 1'b0;
    checks++;
    if (alarm_ring !== 1'b1 || !ok) begin
      failures++; $display("FAIL ring_start got=%b exp=1", alarm_ring);
    end
    cyc(1);
    checks++;
    if (digits !== 16'h0002) begin failures++; $display("FAIL ring_time got=%h exp=0002", digits); end
    inc = 1'b1; cyc(1); inc = 1'b0;
    checks++;
    if (alarm_ring !== 1'b0) begin failures++; $display("FAIL dismiss got=%b exp=0", alarm_ring); end
    amset = 1'b1; pulses(1); amset = 1'b0;
    clockon = 1'b1;
    run_ticks(60, ok);
    checks++;
    if (alarm_ring !== 1'b1 || !ok) begin
      failures++; $display("FAIL ring2_start got=%b exp=1", alarm_ring);
    end
    for (int c = 0; c < RS * DIV + 2 * DIV; c++) begin
      if (alarm_ring !== 1'b1) break;
      if (tick === 1'b1) rt++;
      cyc(1);
    end
    clockon = 1'b0;
    checks++;
    if (rt !== RS || alarm_ring !== 1'b0) begin
      failures++; $display("FAIL ring_len got=%0d/%b exp=%0d/0", rt, alarm_ring, RS);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    mset = 1'b1; pulses(1); mset = 1'b0;
    amset = 1'b1; pulses(2); amset = 1'b0;
    h1224 = 1'b1; clockon = 1'b1;
    run_ticks(60, ok);
    for (int c = 0; c < DIV; c++) begin
      if (tick === 1'b1) break;
      cyc(1);
    end
    checks++;
    if ({alarm_ring, tick, digits} !== {2'b11, 16'h1205}) begin
      failures++; $display("FAIL pre_reset got=%b%b/%h exp=11/1205", alarm_ring, tick, digits);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({alarm_ring, tick, pm, digits} !== {3'b000, 16'h0000}) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b/%h exp=000/0000", alarm_ring, tick, pm, digits);
    end
    clockon = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    checks++;
    if (tick !== 1'b0) begin failures++; $display("FAIL tick_early got=%b exp=0", tick); end
    cyc(1);
    checks++;
    if ({tick, digits} !== {1'b1, 16'h1200}) begin
      failures++; $display("FAIL post_reset got=%b/%h exp=1/1200", tick, digits);
    end
    sel1 = 1'b0;
    cyc(1);
    checks++;
    if ({digits, alarm_ring} !== {16'h1200, 1'b0}) begin
      failures++; $display("FAIL alarm_cleared got=%h/%b exp=1200/0", digits, alarm_ring);
    end
  endtask

  initial begin
    reset = 1'b0; inc = 1'b0; clockon = 1'b0; hset = 1'b0; mset = 1'b0;
    alarmon = 1'b0; ahset = 1'b0; amset = 1'b0; h1224 = 1'b0; sel1 = 1'b1; sel2 = 1'b0;
    test_reset;
    test_tick;
    test_rollover;
    test_hour12;
    test_priority;
    test_alarm;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
